// File: rtl/alu_pkg.sv
// Shared ALU opcode constants, default width and a small opcode helper.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  localparam logic [3:0] ALU_EQ  = 4'b1111;

  // True when the opcode belongs to the supported set.
  function automatic logic alu_op_known(input logic [3:0] op);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_NOR, ALU_EQ: alu_op_known = 1'b1;
      default:                  alu_op_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, carry/no-borrow, signed overflow, bad opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             op_err
);

  logic [WIDTH-1:0] and_bits;
  logic [WIDTH-1:0] or_bits;
  logic [WIDTH-1:0] nor_bits;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt_bit;

  // Bitwise logic unit, one slice per bit.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
      assign and_bits[gi] = a[gi] & b[gi];
      assign or_bits[gi]  = a[gi] | b[gi];
      assign nor_bits[gi] = ~(a[gi] | b[gi]);
    end
  endgenerate

  // Subtraction is A + ~B + 1, so the top bit is the "no borrow" flag.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
  assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
  // Signed less-than: sign of A-B corrected by its overflow.
  assign slt_bit = diff_ext[WIDTH-1] ^ sub_ovf;

  // Opcode select; carry/overflow stay low outside ADD and SUB.
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    op_err   = !alu_op_known(ctrl);
    case (ctrl)
      ALU_AND: result = and_bits;
      ALU_OR:  result = or_bits;
      ALU_NOR: result = nor_bits;
      ALU_ADD: begin
        result   = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        overflow = add_ovf;
      end
      ALU_SUB: begin
        result   = diff_ext[WIDTH-1:0];
        carry    = diff_ext[WIDTH];
        overflow = sub_ovf;
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, slt_bit};
      ALU_EQ:  result = {{(WIDTH-1){1'b0}}, (a == b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe_resp.sv
// Two-stage valid/ready ALU responder: operand register, then result register.
module alu_pipe_resp
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic [3:0]       ALU_ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_out,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             op_err,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  logic [3:0]       s1_ctrl_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic             out_valid_reg;
  logic [WIDTH-1:0] out_result_reg;
  logic             out_carry_reg;
  logic             out_zero_reg;
  logic             out_ovf_reg;
  logic             out_err_reg;
  logic [TAG_W-1:0] out_tag_reg;

  logic [WIDTH-1:0] result_next;
  logic             carry_next;
  logic             ovf_next;
  logic             err_next;

  logic             out_adv;
  logic             s1_adv;

  // A stage may advance when it is empty or its successor advances; in_ready
  // therefore follows out_ready combinationally when both stages are full.
  assign out_adv  = !out_valid_reg || out_ready;
  assign s1_adv   = !s1_valid_reg || out_adv;
  assign in_ready = s1_adv;

  // Stage 1: capture operands, opcode and tag on an input transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_ctrl_reg  <= '0;
      s1_tag_reg   <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_a_reg    <= A_in;
        s1_b_reg    <= B_in;
        s1_ctrl_reg <= ALU_ctrl;
        s1_tag_reg  <= in_tag;
      end
    end
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (s1_a_reg),
    .b        (s1_b_reg),
    .ctrl     (s1_ctrl_reg),
    .result   (result_next),
    .carry    (carry_next),
    .overflow (ovf_next),
    .op_err   (err_next)
  );

  // Stage 2: register the result; data only changes when a new op moves in,
  // so an empty bubble leaves the last result visible but unflagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_result_reg <= '0;
      out_carry_reg  <= 1'b0;
      out_zero_reg   <= 1'b0;
      out_ovf_reg    <= 1'b0;
      out_err_reg    <= 1'b0;
      out_tag_reg    <= '0;
    end else if (out_adv) begin
      out_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        out_result_reg <= result_next;
        out_carry_reg  <= carry_next;
        out_zero_reg   <= (result_next == '0);
        out_ovf_reg    <= ovf_next;
        out_err_reg    <= err_next;
        out_tag_reg    <= s1_tag_reg;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign ALU_out   = out_result_reg;
  assign carry_out = out_carry_reg;
  assign zero      = out_zero_reg;
  assign overflow  = out_ovf_reg;
  assign op_err    = out_err_reg;
  assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_alu_pipe_resp.sv
// Self-checking bench: directed vector table, handshake corner cases, random regression.
module tb_alu_pipe_resp;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] A_in = '0;
  logic [WIDTH-1:0] B_in = '0;
  logic [3:0]       ALU_ctrl = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] ALU_out;
  logic             carry_out;
  logic             zero;
  logic             overflow;
  logic             op_err;
  logic [TAG_W-1:0] out_tag;

  alu_pipe_resp #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A_in      (A_in),
    .B_in      (B_in),
    .ALU_ctrl  (ALU_ctrl),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_out   (ALU_out),
    .carry_out (carry_out),
    .zero      (zero),
    .overflow  (overflow),
    .op_err    (op_err),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             z;
    logic             e;
    logic [TAG_W-1:0] tag;
  } resp_t;

  typedef struct {
    logic [3:0]       ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
    logic             c;
    logic             v;
    logic             z;
    logic             e;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_out    = 0;
  logic  in_fire  = 1'b0;
  resp_t sb[$];
  logic  hold_pending = 1'b0;
  resp_t held;
  vec_t  vecs[15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference: plain integer arithmetic and signed comparisons.
  function automatic resp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    resp_t r;
    logic [32:0] s;
    r.res = '0; r.c = 1'b0; r.v = 1'b0; r.e = 1'b0; r.tag = '0;
    case (op)
      4'b0000: r.res = a & b;
      4'b0001: r.res = a | b;
      4'b1100: r.res = ~(a | b);
      4'b0010: begin
        s = a + b; // 33-bit context keeps the carry
        r.res = s[31:0]; r.c = s[32];
        r.v = ($signed(a) < 0) == ($signed(b) < 0) && (($signed(r.res) < 0) != ($signed(a) < 0));
      end
      4'b0110: begin
        r.res = a - b; r.c = (a >= b);
        r.v = ($signed(a) < 0) != ($signed(b) < 0) && (($signed(r.res) < 0) != ($signed(a) < 0));
      end
      4'b0111: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1111: r.res = (a == b) ? 32'd1 : 32'd0;
      default: r.e = 1'b1;
    endcase
    r.z = (r.res == 0);
    return r;
  endfunction

  function automatic resp_t vec_resp(input vec_t v);
    resp_t r;
    r.res = v.res; r.c = v.c; r.v = v.v; r.z = v.z; r.e = v.e; r.tag = '0;
    return r;
  endfunction

  // One clock cycle with inputs already driven: bookkeeping of both
  // handshakes, hold-stability while stalled, then advance to edge+1.
  task automatic cycle(input resp_t exp_in);
    resp_t e;
    #1;
    if (hold_pending) begin
      check("hold_valid", out_valid, 1);
      check("hold_res", ALU_out, held.res);
      check("hold_flags", {carry_out, overflow, zero, op_err}, {held.c, held.v, held.z, held.e});
      check("hold_tag", out_tag, held.tag);
    end
    hold_pending = out_valid && !out_ready;
    held.res = ALU_out; held.c = carry_out; held.v = overflow;
    held.z = zero; held.e = op_err; held.tag = out_tag;
    in_fire = in_valid && in_ready;
    if (in_fire) begin
      e = exp_in;
      e.tag = in_tag;
      sb.push_back(e);
    end
    if (out_valid && out_ready) begin
      n_out++;
      check("out_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("res", ALU_out, e.res);
        check("carry", carry_out, e.c);
        check("ovf", overflow, e.v);
        check("zero", zero, e.z);
        check("op_err", op_err, e.e);
        check("tag", out_tag, e.tag);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic [TAG_W-1:0] t);
    in_valid = 1'b1; A_in = v.a; B_in = v.b; ALU_ctrl = v.ctrl; in_tag = t;
  endtask

  // Keep offering until accepted; an expired budget is a failure.
  task automatic offer_until_accepted(input vec_t v, input logic [TAG_W-1:0] t, input int budget);
    int k;
    drive(v, t);
    k = 0;
    do begin
      cycle(vec_resp(v));
      k++;
    end while (!in_fire && k < budget);
    check("accept_timeout", in_fire, 1);
    in_valid = 1'b0;
  endtask

  resp_t idle;
  int    out_before;
  vec_t  rv;

  initial begin
    idle = model(4'b0000, 0, 0);
    //            ctrl     A             B             result        c     v     z     e
    vecs[0]  = '{4'b0010, 32'ha86a0c31, 32'h90073fd4, 32'h38714c05, 1'b1, 1'b1, 1'b0, 1'b0}; // ADD smoke
    vecs[1]  = '{4'b0110, 32'ha86a0c31, 32'h90073fd4, 32'h1862cc5d, 1'b1, 1'b0, 1'b0, 1'b0}; // SUB
    vecs[2]  = '{4'b0111, 32'ha86a0c31, 32'h90073fd4, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0}; // SLT
    vecs[3]  = '{4'b1100, 32'ha86a0c31, 32'h90073fd4, 32'h4790c00a, 1'b0, 1'b0, 1'b0, 1'b0}; // NOR
    vecs[4]  = '{4'b1111, 32'ha86a0c31, 32'ha86a0c31, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0}; // EQ
    vecs[5]  = '{4'b0000, 32'h086a0c31, 32'hd785f148, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0}; // AND
    vecs[6]  = '{4'b0101, 32'h086a0c31, 32'hd785f148, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1}; // bad op
    vecs[7]  = '{4'b0001, 32'ha86a0c31, 32'h90073fd4, 32'hb86f3ff5, 1'b0, 1'b0, 1'b0, 1'b0}; // OR
    vecs[8]  = '{4'b0010, 32'h7fffffff, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0}; // ADD +ovf
    vecs[9]  = '{4'b0110, 32'h00000000, 32'h00000001, 32'hffffffff, 1'b0, 1'b0, 1'b0, 1'b0}; // SUB borrow
    vecs[10] = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1, 1'b1, 1'b0, 1'b0}; // SUB ovf
    vecs[11] = '{4'b0111, 32'h80000000, 32'h7fffffff, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0}; // SLT ovf case
    vecs[12] = '{4'b0111, 32'h00000001, 32'hffffffff, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0}; // SLT 1 < -1 ?
    vecs[13] = '{4'b1111, 32'h00000005, 32'h00000004, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0}; // EQ false
    vecs[14] = '{4'b1010, 32'hffffffff, 32'hffffffff, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b1}; // bad op

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_ALU_out", ALU_out, 0);
    check("rst_flags", {carry_out, overflow, zero, op_err}, 4'b0000);
    check("rst_out_tag", out_tag, 0);

    // Table: each op alone, 2-cycle latency, results checked against the table.
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      out_before = n_out;
      drive(vecs[i], 4'(i));
      cycle(vec_resp(vecs[i]));
      check("vec_accept", in_fire, 1);
      in_valid = 1'b0;
      check("lat_not_yet", out_valid, 0);
      cycle(idle);
      check("lat_valid", out_valid, 1);
      cycle(idle);
      check("vec_one_out", n_out - out_before, 1);
      $display("vec %0d ctrl=%b A=%h B=%h -> out=%h c%0b v%0b z%0b e%0b tag=%0d",
               i, vecs[i].ctrl, vecs[i].a, vecs[i].b, held.res, held.c, held.v, held.z, held.e, held.tag);
    end

    // Back-to-back SUB, SLT, NOR, EQ with tags 1..4; results in consecutive cycles.
    out_before = n_out;
    for (int i = 1; i <= 4; i++) begin
      drive(vecs[i], 4'(i));
      cycle(vec_resp(vecs[i]));
      check("b2b_accept", in_fire, 1);
    end
    in_valid = 1'b0;
    cycle(idle);
    cycle(idle);
    check("b2b_count", n_out - out_before, 4);
    check("b2b_drained", sb.size(), 0);

    // Backpressure: two accepted, third stalls with in_ready low, outputs held.
    out_ready = 1'b0;
    out_before = n_out;
    offer_until_accepted(vecs[0], 4'd5, 4);
    offer_until_accepted(vecs[3], 4'd6, 4);
    drive(vecs[7], 4'd7);
    for (int k = 0; k < 4; k++) begin
      cycle(vec_resp(vecs[7]));
      check("bp_in_ready_low", in_fire, 0);
    end
    check("bp_no_out", n_out - out_before, 0);
    out_ready = 1'b1;
    offer_until_accepted(vecs[7], 4'd7, 4);
    for (int k = 0; k < 4; k++) cycle(idle);
    check("bp_drain_count", n_out - out_before, 3);
    check("bp_drained", sb.size(), 0);

    // Reset mid-flight: both in-flight results must vanish.
    out_ready = 1'b0;
    offer_until_accepted(vecs[1], 4'd8, 4);
    offer_until_accepted(vecs[2], 4'd9, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    hold_pending = 1'b0;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    out_before = n_out;
    for (int k = 0; k < 5; k++) cycle(idle);
    check("mid_rst_no_out", n_out - out_before, 0);

    // Random regression against the reference model, valid held until accepted.
    begin
      int issued;
      int cyc;
      logic [3:0] ops[10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111,
                              4'b1100, 4'b1111, 4'b0011, 4'b1000, 4'b1110};
      issued = 0;
      cyc = 0;
      in_fire = 1'b1;
      while (issued < 10000 && cyc < 60000) begin
        if (in_fire || !in_valid) begin
          if ($urandom_range(0, 99) < 70) begin
            rv.ctrl = ops[$urandom_range(0, 9)];
            rv.a = $urandom;
            case ($urandom_range(0, 3))
              0: rv.b = rv.a;
              1: rv.b = {1'b1, 31'($urandom_range(0, 3))};
              default: rv.b = $urandom;
            endcase
            drive(rv, 4'($urandom_range(0, 15)));
          end else begin
            in_valid = 1'b0;
          end
        end
        out_ready = ($urandom_range(0, 99) < 70);
        cycle(model(ALU_ctrl, A_in, B_in));
        if (in_fire) issued++;
        cyc++;
      end
      check("rand_issued", issued, 10000);
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) cycle(idle);
      check("rand_drained", sb.size(), 0);
      $display("random: %0d ops in %0d cycles, %0d results", issued, cyc, n_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
